// File: rtl/num_combiner.sv
// Accumulates BCD digits (most significant first) into a binary number, publishing it on enter.
// Each accepted digit costs one multiply-accumulate cycle; overflow, illegal digits and excess digits latch an error.
module num_combiner #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             enter,
  output logic             ready,
  output logic [WIDTH-1:0] numero,
  output logic             done,
  output logic             error
);

  localparam int CW = (DIGITS < 1) ? 1 : $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_MAC,
    S_ERROR
  } state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [3:0]     dig;
  logic [WIDTH+3:0] mac_sum;
  logic           mac_fault;
  logic           take_digit;
  logic           take_enter;

  // Wide enough that acc*10 + 15 cannot wrap, so overflow is just the upper nibble.
  assign mac_sum   = {4'b0000, acc} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, dig};
  assign mac_fault = (dig > 4'd9) || (mac_sum[WIDTH+3:WIDTH] != 4'b0000) || (cnt == CW'(DIGITS));

  assign take_digit = ready && digit_valid;
  assign take_enter = ready && enter && !digit_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (digit_valid) begin
          state_nxt = S_MAC;
        end else if (enter) begin
          state_nxt = S_IDLE;
        end
      end
      S_MAC:   state_nxt = mac_fault ? S_ERROR : S_COLLECT;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    ready = 1'b0;
    error = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: ready = 1'b1;
      S_ERROR:           error = 1'b1;
      default: begin
        ready = 1'b0;
        error = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      dig    <= '0;
      numero <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == S_MAC) begin
        if (!mac_fault) begin
          acc <= mac_sum[WIDTH-1:0];
          cnt <= cnt + 1'b1;
        end
      end else if (take_digit) begin
        dig <= digit;
      end else if (take_enter) begin
        numero <= acc;
        done   <= 1'b1;
        acc    <= '0;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_num_combiner.sv
// Drives two instances (default and three-digit) against a transaction-level decimal model.
module tb_num_combiner;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] digit;
  logic       digit_valid;
  logic       enter;
  logic       sel;

  logic       ready0, done0, error0, ready1, done1, error1;
  logic [7:0] numero0, numero1;

  int checks = 0;
  int errors = 0;

  int m_val;
  int m_n;
  int m_numero;
  bit m_err;

  always #5 clk = ~clk;

  num_combiner #(.WIDTH(8), .DIGITS(2)) dut0 (
    .clk(clk), .reset(reset), .clear(clear & ~sel), .digit(digit),
    .digit_valid(digit_valid & ~sel), .enter(enter & ~sel),
    .ready(ready0), .numero(numero0), .done(done0), .error(error0)
  );

  num_combiner #(.WIDTH(8), .DIGITS(3)) dut1 (
    .clk(clk), .reset(reset), .clear(clear & sel), .digit(digit),
    .digit_valid(digit_valid & sel), .enter(enter & sel),
    .ready(ready1), .numero(numero1), .done(done1), .error(error1)
  );

  wire       ready_s  = sel ? ready1  : ready0;
  wire       done_s   = sel ? done1   : done0;
  wire       error_s  = sel ? error1  : error0;
  wire [7:0] numero_s = sel ? numero1 : numero0;
  wire [7:0] acc_s    = sel ? dut1.acc : dut0.acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int max_digits();
    return sel ? 3 : 2;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_val = 0; m_n = 0; m_numero = 0; m_err = 1'b0;
    check("rst_ready", ready_s, 1);
    check("rst_error", error_s, 0);
    check("rst_done", done_s, 0);
    check("rst_numero", numero_s, 0);
  endtask

  task automatic wait_ready();
    int budget = 20;
    while (!ready_s && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("ready_timeout", 0, 1);
  endtask

  task automatic model_digit(input int d);
    if (d > 9 || m_n == max_digits() || m_val * 10 + d > 255) begin
      m_err = 1'b1;
    end else begin
      m_val = m_val * 10 + d;
      m_n++;
    end
  endtask

  task automatic send_digit(input int d);
    wait_ready();
    digit = 4'(d);
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    check("accept_busy", ready_s, 0);
    tick();
    model_digit(d);
    check("mac_error", error_s, 32'(m_err));
    check("mac_ready", ready_s, 32'(!m_err));
    check("mac_acc", acc_s, m_val);
  endtask

  task automatic send_enter();
    wait_ready();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    m_numero = m_val;
    m_val = 0;
    m_n = 0;
    check("enter_done", done_s, 1);
    check("enter_numero", numero_s, m_numero);
    tick();
    check("done_drop", done_s, 0);
    check("enter_ready", ready_s, 1);
  endtask

  task automatic enter_ignored();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    check("err_enter_done", done_s, 0);
    check("err_numero", numero_s, m_numero);
    check("err_sticky", error_s, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_val = 0; m_n = 0; m_err = 1'b0;
    check("clr_error", error_s, 0);
    check("clr_ready", ready_s, 1);
    check("clr_done", done_s, 0);
    check("clr_acc", acc_s, 0);
    check("clr_numero", numero_s, m_numero);
  endtask

  task automatic entry(input int v);
    if (v >= 10) send_digit(v / 10);
    send_digit(v % 10);
    send_enter();
    check("sweep_value", numero_s, v);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; digit = '0; digit_valid = 1'b0; enter = 1'b0; sel = 1'b0;
    tick();
    do_reset();

    // Two digits.
    send_digit(2);
    send_digit(5);
    send_enter();
    check("two_digit", numero_s, 25);
    check("two_digit_err", error_s, 0);

    // Full sweep, plus leading-zero form for single digits.
    for (int v = 0; v < 100; v++) begin
      entry(v);
      if (v < 10) begin
        send_digit(0);
        send_digit(v);
        send_enter();
        check("sweep_lead0", numero_s, v);
      end
    end

    // Too many digits: acc stops at 12.
    send_digit(1);
    send_digit(2);
    send_digit(3);
    check("cnt_fault_acc", acc_s, 12);
    enter_ignored();
    do_clear();

    // Illegal digit.
    send_digit(10);
    check("illegal_err", error_s, 1);
    do_clear();

    // digit_valid held: accepted on alternate cycles only.
    wait_ready();
    digit = 4'd1;
    digit_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("held_ready", ready_s, (k % 2 == 1) ? 1 : 0);
    end
    digit_valid = 1'b0;
    model_digit(1);
    model_digit(1);
    check("held_acc", acc_s, m_val);
    send_enter();

    // Simultaneous digit and enter: digit wins.
    digit = 4'd6;
    digit_valid = 1'b1;
    enter = 1'b1;
    tick();
    digit_valid = 1'b0;
    enter = 1'b0;
    check("simul_done", done_s, 0);
    check("simul_busy", ready_s, 0);
    tick();
    model_digit(6);
    check("simul_acc", acc_s, m_val);
    send_enter();

    // Enter with no digits publishes 0.
    send_enter();
    check("empty_numero", numero_s, 0);

    // Clear during MAC.
    send_digit(4);
    send_enter();
    digit = 4'd7;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    do_clear();

    // Reset mid-entry.
    send_digit(3);
    do_reset();

    // Randomised entries on both widths.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int e = 0; e < 150; e++) begin
        int nd = $urandom_range(0, 4);
        for (int i = 0; i < nd; i++) begin
          if (!m_err) begin
            int d = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            send_digit(d);
          end
        end
        if (m_err) begin
          enter_ignored();
          do_clear();
        end else begin
          send_enter();
        end
      end
    end

    // Overflow at the 8-bit limit with three digits.
    sel = 1'b1;
    do_reset();
    send_digit(2);
    send_digit(5);
    send_digit(5);
    send_enter();
    check("ovf_255", numero_s, 255);
    send_digit(2);
    send_digit(5);
    send_digit(6);
    check("ovf_err", error_s, 1);
    enter_ignored();
    check("ovf_hold", numero_s, 255);
    do_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
